// File: rtl/mac_pkg.sv
// Shared constants and types for the pipelined signed multiply-accumulate block.
package mac_pkg;

  localparam logic MAC_MODE_MUL   = 1'b0;
  localparam logic MAC_MODE_ACC   = 1'b1;
  localparam int   MAC_MIN_STAGES = 2;
  localparam int   MAC_MAX_ACC_W  = 64;

  // One pipeline slot as it appears on a waveform: flags plus the widest product.
  typedef struct packed {
    logic                            val;
    logic                            acc;
    logic                            last;
    logic signed [MAC_MAX_ACC_W-1:0] product;
  } mac_stage_t;

endpackage

// File: rtl/mac_pipe_stage.sv
// One pipeline register slot (valid, acc/last flags, data); 1 cycle latency.
// Holds its contents while en is low; synchronous active-high reset clears it.
module mac_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         in_val,
  input  logic         in_acc,
  input  logic         in_last,
  input  logic [W-1:0] in_dat,
  output logic         out_val,
  output logic         out_acc,
  output logic         out_last,
  output logic [W-1:0] out_dat
);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_val  <= 1'b0;
      out_acc  <= 1'b0;
      out_last <= 1'b0;
      out_dat  <= '0;
    end else if (en) begin
      out_val  <= in_val;
      out_acc  <= in_acc;
      out_last <= in_last;
      out_dat  <= in_dat;
    end
  end

endmodule

// File: rtl/pipelined_signed_mac.sv
// Pipelined signed multiplier with grouped accumulation; STAGES cycles latency.
// A held output (out_val && !out_rdy) freezes every stage and drops in_rdy.
module pipelined_signed_mac
  import mac_pkg::*;
#(
  parameter int A_WIDTH   = 8,
  parameter int B_WIDTH   = 12,
  parameter int STAGES    = 3,
  parameter int ACC_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_val,
  output logic                 in_rdy,
  input  logic [A_WIDTH-1:0]   a,
  input  logic [B_WIDTH-1:0]   b,
  input  logic                 acc,
  input  logic                 last,
  output logic                 out_val,
  input  logic                 out_rdy,
  output logic [ACC_WIDTH-1:0] out
);

  localparam int CAP_W = A_WIDTH + B_WIDTH;

  if (ACC_WIDTH < CAP_W || STAGES < MAC_MIN_STAGES || ACC_WIDTH > MAC_MAX_ACC_W) begin : g_cfg_err
    $error("pipelined_signed_mac: illegal STAGES/ACC_WIDTH configuration");
  end

  logic                        stall;
  logic                        adv;
  logic                        s_val  [1:STAGES-1];
  logic                        s_acc  [1:STAGES-1];
  logic                        s_last [1:STAGES-1];
  logic [CAP_W-1:0]            cap_dat;
  logic signed [ACC_WIDTH-1:0] p_dat  [1:STAGES-1];
  logic signed [ACC_WIDTH-1:0] a_ext;
  logic signed [ACC_WIDTH-1:0] b_ext;
  logic signed [ACC_WIDTH-1:0] sum;
  logic signed [ACC_WIDTH-1:0] sum_next;
  logic signed [ACC_WIDTH-1:0] fin_prod;
  logic                        fin_val;
  logic                        fin_acc;
  logic                        fin_last;

  assign stall  = out_val && !out_rdy;
  assign adv    = !stall;
  assign in_rdy = adv;

  // Product is formed right after operand capture; p_dat[1] is combinational.
  assign a_ext    = {{(ACC_WIDTH-A_WIDTH){cap_dat[CAP_W-1]}}, cap_dat[CAP_W-1:B_WIDTH]};
  assign b_ext    = {{(ACC_WIDTH-B_WIDTH){cap_dat[B_WIDTH-1]}}, cap_dat[B_WIDTH-1:0]};
  assign p_dat[1] = a_ext * b_ext;

  for (genvar k = 1; k < STAGES; k++) begin : g_stage
    if (k == 1) begin : g_cap
      mac_pipe_stage #(.W(CAP_W)) u_stage (
        .clk      (clk),
        .reset    (reset),
        .en       (adv),
        .in_val   (in_val),
        .in_acc   (acc),
        .in_last  (last),
        .in_dat   ({a, b}),
        .out_val  (s_val[1]),
        .out_acc  (s_acc[1]),
        .out_last (s_last[1]),
        .out_dat  (cap_dat)
      );
    end else begin : g_dly
      mac_pipe_stage #(.W(ACC_WIDTH)) u_stage (
        .clk      (clk),
        .reset    (reset),
        .en       (adv),
        .in_val   (s_val[k-1]),
        .in_acc   (s_acc[k-1]),
        .in_last  (s_last[k-1]),
        .in_dat   (p_dat[k-1]),
        .out_val  (s_val[k]),
        .out_acc  (s_acc[k]),
        .out_last (s_last[k]),
        .out_dat  (p_dat[k])
      );
    end
  end

  assign fin_val  = s_val[STAGES-1];
  assign fin_acc  = s_acc[STAGES-1];
  assign fin_last = s_last[STAGES-1];
  assign fin_prod = p_dat[STAGES-1];
  assign sum_next = sum + fin_prod;

  // Plain multiplies bypass the sum so they can sit inside an open group.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_val <= 1'b0;
      out     <= '0;
      sum     <= '0;
    end else if (adv) begin
      out_val <= 1'b0;
      if (fin_val) begin
        if (fin_acc == MAC_MODE_MUL) begin
          out     <= fin_prod;
          out_val <= 1'b1;
        end else if (!fin_last) begin
          sum <= sum_next;
        end else begin
          out     <= sum_next;
          out_val <= 1'b1;
          sum     <= '0;
        end
      end
    end
  end

endmodule
